// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot state codes, parity modes and the parity helper.
package uart_pkg;

   localparam int unsigned ST_W = 6;

   localparam logic [ST_W-1:0] ST_IDLE   = 6'b00_0001;
   localparam logic [ST_W-1:0] ST_START  = 6'b00_0010;
   localparam logic [ST_W-1:0] ST_DATA   = 6'b00_0100;
   localparam logic [ST_W-1:0] ST_PARITY = 6'b00_1000;
   localparam logic [ST_W-1:0] ST_STOP   = 6'b01_0000;
   localparam logic [ST_W-1:0] ST_DONE   = 6'b10_0000;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_XOR  = 1;
   localparam int unsigned PARITY_XNOR = 2;

   typedef enum logic [ST_W-1:0] {
      S_IDLE   = ST_IDLE,
      S_START  = ST_START,
      S_DATA   = ST_DATA,
      S_PARITY = ST_PARITY,
      S_STOP   = ST_STOP,
      S_DONE   = ST_DONE
   } state_e;

   // Expected parity bit given the XOR-reduction of the data word.
   function automatic logic parity_expected(input logic data_xor, input int unsigned mode);
      return (mode == PARITY_XNOR) ? ~data_xor : data_xor;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with selectable reset value.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, centre sampling of data/parity/stop,
// one-cycle done pulse with parity and framing error flags.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WD           = 8,
   parameter int unsigned OVERSAMPLING_RATE = 16,
   parameter int unsigned PARITY            = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               rx,
   output logic [DATA_WD-1:0] dout,
   output logic               rx_done,
   output logic               rx_busy,
   output logic               parity_err,
   output logic               frame_err
);

   localparam int unsigned TICK_W = $clog2(OVERSAMPLING_RATE);
   localparam int unsigned BIT_W  = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;

   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLING_RATE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLING_RATE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WD - 1);

   logic rx_s;

   state_e              state_q,      state_d;
   logic [TICK_W-1:0]   tick_cnt_q,   tick_cnt_d;
   logic [BIT_W-1:0]    bit_idx_q,    bit_idx_d;
   logic [DATA_WD-1:0]  shift_q,      shift_d;
   logic                armed_q,      armed_d;
   logic                par_bad_q,    par_bad_d;
   logic                frame_bad_q,  frame_bad_d;
   logic [DATA_WD-1:0]  dout_q,       dout_d;
   logic                rx_done_q,    rx_done_d;
   logic                rx_busy_q,    rx_busy_d;
   logic                parity_err_q, parity_err_d;
   logic                frame_err_q,  frame_err_d;

   logic bit_point;
   logic mid_point;

   uart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   assign bit_point = tick && (tick_cnt_q == TICK_LAST);
   assign mid_point = tick && (tick_cnt_q == TICK_MID);

   // Next-state and output computation; any state change also restarts the tick counter.
   always_comb begin
      state_d      = state_q;
      tick_cnt_d   = tick_cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      armed_d      = armed_q;
      par_bad_d    = par_bad_q;
      frame_bad_d  = frame_bad_q;
      dout_d       = dout_q;
      rx_done_d    = 1'b0;
      rx_busy_d    = rx_busy_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;

      if (tick) begin
         tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TICK_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            tick_cnt_d = '0;
            if (rx_s) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               state_d   = S_START;
               armed_d   = 1'b0;
               rx_busy_d = 1'b1;
               bit_idx_d = '0;
            end
         end

         S_START: begin
            if (mid_point) begin
               tick_cnt_d = '0;
               if (rx_s) begin
                  state_d   = S_IDLE;
                  rx_busy_d = 1'b0;
               end else begin
                  state_d = S_DATA;
               end
            end
         end

         S_DATA: begin
            if (bit_point) begin
               tick_cnt_d         = '0;
               shift_d[bit_idx_q] = rx_s;
               bit_idx_d          = bit_idx_q + BIT_W'(1);
               if (bit_idx_q == BIT_LAST) begin
                  bit_idx_d = '0;
                  state_d   = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
               end
            end
         end

         S_PARITY: begin
            if (bit_point) begin
               tick_cnt_d = '0;
               par_bad_d  = (rx_s != parity_expected(^shift_q, PARITY));
               state_d    = S_STOP;
            end
         end

         // Leave at the stop-bit centre so back-to-back frames keep half a bit of margin.
         S_STOP: begin
            if (bit_point) begin
               tick_cnt_d  = '0;
               frame_bad_d = ~rx_s;
               state_d     = S_DONE;
            end
         end

         S_DONE: begin
            tick_cnt_d   = '0;
            dout_d       = shift_q;
            rx_done_d    = 1'b1;
            parity_err_d = (PARITY != PARITY_NONE) ? par_bad_q : 1'b0;
            frame_err_d  = frame_bad_q;
            rx_busy_d    = 1'b0;
            state_d      = S_IDLE;
         end

         default: begin
            state_d    = S_IDLE;
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            armed_d    = 1'b0;
            rx_busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         tick_cnt_q   <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         armed_q      <= 1'b0;
         par_bad_q    <= 1'b0;
         frame_bad_q  <= 1'b0;
         dout_q       <= '0;
         rx_done_q    <= 1'b0;
         rx_busy_q    <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         tick_cnt_q   <= tick_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         armed_q      <= armed_d;
         par_bad_q    <= par_bad_d;
         frame_bad_q  <= frame_bad_d;
         dout_q       <= dout_d;
         rx_done_q    <= rx_done_d;
         rx_busy_q    <= rx_busy_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign dout       = dout_q;
   assign rx_done    = rx_done_q;
   assign rx_busy    = rx_busy_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three receivers (no parity, XOR parity, XNOR parity) fed directed
// and random frames, checked against a frame-level model of what the line carried.
module tb_uart_rx;

   localparam int unsigned OSR  = 16;
   localparam int unsigned NDUT = 3;

   typedef struct packed {
      logic [1:0] idx;
      logic [7:0] d;
      logic       pe;
      logic       fe;
      logic       busy_before;
   } ev_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            tick;
   logic [NDUT-1:0] rx_v;
   logic [NDUT-1:0] done_w, busy_w, perr_w, ferr_w;
   logic [7:0]      dout_w [NDUT];

   int   n_tests = 0;
   int   n_fail  = 0;
   int   dbl_cnt = 0;
   ev_t  evq[$];
   logic [NDUT-1:0] done_prev = '0;
   logic [NDUT-1:0] busy_prev = '0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      uart_rx #(.DATA_WD(8), .OVERSAMPLING_RATE(OSR), .PARITY(g)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .tick       (tick),
         .rx         (rx_v[g]),
         .dout       (dout_w[g]),
         .rx_done    (done_w[g]),
         .rx_busy    (busy_w[g]),
         .parity_err (perr_w[g]),
         .frame_err  (ferr_w[g])
      );
   end

   // Baud tick: one clk high out of every four.
   initial begin
      tick = 1'b0;
      forever begin
         repeat (3) @(posedge clk);
         #1 tick = 1'b1;
         @(posedge clk);
         #1 tick = 1'b0;
      end
   end

   // Record every done pulse with the flags and whether busy was high in the cycle before.
   always @(negedge clk) begin
      ev_t e;
      for (int i = 0; i < NDUT; i++) begin
         if (done_w[i]) begin
            e.idx         = 2'(i);
            e.d           = dout_w[i];
            e.pe          = perr_w[i];
            e.fe          = ferr_w[i];
            e.busy_before = busy_prev[i];
            evq.push_back(e);
            if (done_prev[i]) dbl_cnt++;
         end
      end
      done_prev = done_w;
      busy_prev = busy_w;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic wait_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         while (tick !== 1'b1) @(posedge clk);
      end
      #1;
   endtask

   task automatic send_bit(input int idx, input logic b);
      rx_v[idx] = b;
      wait_ticks(OSR);
   endtask

   function automatic logic model_par_bit(input int idx, input logic [7:0] d);
      int ones;
      ones = $countones(d);
      return (idx == 1) ? logic'(ones % 2) : logic'(1 - (ones % 2));
   endfunction

   // Frame: optional idle gap, start, 8 data bits LSB first, parity (DUT 1/2 only), stop.
   task automatic send_frame(input int idx, input logic [7:0] d, input logic par_ok,
                             input logic stop, input int gap);
      if (gap > 0) begin
         rx_v[idx] = 1'b1;
         wait_ticks(gap);
      end
      send_bit(idx, 1'b0);
      chk($sformatf("busy_in_frame_dut%0d", idx), 32'(busy_w[idx]), 32'd1);
      for (int b = 0; b < 8; b++) send_bit(idx, d[b]);
      if (idx != 0) send_bit(idx, par_ok ? model_par_bit(idx, d) : ~model_par_bit(idx, d));
      send_bit(idx, stop);
   endtask

   task automatic expect_frame(input string tag, input int idx, input logic [7:0] d,
                               input logic pe, input logic fe);
      ev_t e;
      int  t;
      t = 0;
      while (evq.size() == 0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_done_seen"}, 32'(evq.size() > 0), 32'd1);
      if (evq.size() > 0) begin
         e = evq.pop_front();
         chk({tag, "_idx"},  32'(e.idx), 32'(idx));
         chk({tag, "_dout"}, 32'(e.d), 32'(d));
         chk({tag, "_perr"}, 32'(e.pe), 32'(pe));
         chk({tag, "_ferr"}, 32'(e.fe), 32'(fe));
         chk({tag, "_busy_thru_done"}, 32'(e.busy_before), 32'd1);
      end
   endtask

   task automatic chk_zero(input string tag, input int idx);
      chk({tag, "_dout"}, 32'(dout_w[idx]), 32'd0);
      chk({tag, "_done"}, 32'(done_w[idx]), 32'd0);
      chk({tag, "_busy"}, 32'(busy_w[idx]), 32'd0);
      chk({tag, "_perr"}, 32'(perr_w[idx]), 32'd0);
      chk({tag, "_ferr"}, 32'(ferr_w[idx]), 32'd0);
   endtask

   initial begin
      logic [7:0] rd;
      logic       good, stop;
      int         ridx;

      rst  = 1'b1;
      rx_v = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) chk_zero($sformatf("reset_dut%0d", i), i);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_ticks(4);

      // Plain frame, no parity.
      send_frame(0, 8'hA5, 1'b1, 1'b1, 2);
      expect_frame("a5", 0, 8'hA5, 1'b0, 1'b0);
      chk("a5_single_pulse", 32'(evq.size()), 32'd0);
      chk("a5_busy_after", 32'(busy_w[0]), 32'd0);

      // XOR parity: correct then wrong parity bit.
      send_frame(1, 8'h3C, 1'b1, 1'b1, 2);
      expect_frame("par_ok", 1, 8'h3C, 1'b0, 1'b0);
      send_frame(1, 8'h3C, 1'b0, 1'b1, 2);
      expect_frame("par_bad", 1, 8'h3C, 1'b1, 1'b0);

      // Framing error, then a break must not retrigger, then recovery.
      send_frame(0, 8'h55, 1'b1, 1'b0, 2);
      expect_frame("ferr", 0, 8'h55, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         wait_ticks(OSR);
         chk($sformatf("break_busy%0d", k), 32'(busy_w[0]), 32'd0);
      end
      chk("break_no_done", 32'(evq.size()), 32'd0);
      send_frame(0, 8'h12, 1'b1, 1'b1, OSR);
      expect_frame("recover", 0, 8'h12, 1'b0, 1'b0);

      // Glitch shorter than half a bit: false start.
      rx_v[0] = 1'b0;
      wait_ticks(3);
      chk("glitch_busy_hi", 32'(busy_w[0]), 32'd1);
      rx_v[0] = 1'b1;
      wait_ticks(OSR);
      chk("glitch_busy_lo", 32'(busy_w[0]), 32'd0);
      chk("glitch_no_done", 32'(evq.size()), 32'd0);
      chk("glitch_dout_kept", 32'(dout_w[0]), 32'h12);
      chk("glitch_ferr_kept", 32'(ferr_w[0]), 32'd0);

      // Back-to-back frames with no idle gap.
      send_frame(0, 8'h00, 1'b1, 1'b1, 2);
      send_frame(0, 8'hFF, 1'b1, 1'b1, 0);
      expect_frame("b2b_first", 0, 8'h00, 1'b0, 1'b0);
      expect_frame("b2b_second", 0, 8'hFF, 1'b0, 1'b0);

      // Reset during data bit 3 of 0x81 aborts the frame.
      rx_v[0] = 1'b1;
      wait_ticks(2);
      send_bit(0, 1'b0);
      send_bit(0, 1'b1);
      send_bit(0, 1'b0);
      send_bit(0, 1'b0);
      rx_v[0] = 1'b0;
      wait_ticks(OSR / 2);
      chk("midrst_busy_before", 32'(busy_w[0]), 32'd1);
      rx_v[0] = 1'b1;
      rst     = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) chk_zero($sformatf("midrst_dut%0d", i), i);
      wait_ticks(2 * OSR);
      chk("midrst_no_done", 32'(evq.size()), 32'd0);
      send_frame(0, 8'h7E, 1'b1, 1'b1, 2);
      expect_frame("after_rst", 0, 8'h7E, 1'b0, 1'b0);

      // Random frames across all parity modes.
      for (int n = 0; n < 12; n++) begin
         ridx = int'($urandom_range(0, NDUT - 1));
         rd   = 8'($urandom);
         good = ($urandom_range(0, 3) != 0);
         stop = ($urandom_range(0, 4) != 0);
         send_frame(ridx, rd, good, stop, 3);
         expect_frame($sformatf("rnd%0d", n), ridx, rd,
                      (ridx != 0) && !good, !stop);
         rx_v = '1;
         wait_ticks(2);
         chk($sformatf("rnd%0d_busy_after", n), 32'(busy_w[ridx]), 32'd0);
      end

      chk("no_double_pulse", 32'(dbl_cnt), 32'd0);
      chk("no_stray_done", 32'(evq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the UART link; counterpart of the uart_tx transmitter on the same link.
- Consumes the shared baud-generator `tick` (OVERSAMPLING_RATE ticks per bit).
- Synchronises the asynchronous `rx` line, detects the start bit and samples each bit at its centre.
- Delivers one parallel word per frame with a one-cycle done pulse plus parity and framing error flags.
- Sits between the pad/line input and the host-side RX FIFO or register interface.

Parameters:
- DATA_WD, 8, data bits per frame, LSB first.
- OVERSAMPLING_RATE, 16, ticks per bit period; even, >= 8.
- PARITY, 0, 0 = none; 1 = parity bit equals XOR of data bits; 2 = parity bit equals XNOR of data bits (same convention as uart_tx).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-clk pulse from baud generator, OVERSAMPLING_RATE per bit.
- rx  in  1  serial line, idle high, asynchronous to clk.
- dout  out  DATA_WD  received word; updated only with rx_done.
- rx_done  out  1  one-clk pulse, frame complete.
- rx_busy  out  1  high from start-edge detection until rx_done.
- parity_err  out  1  parity mismatch of last frame; 0 when PARITY = 0.
- frame_err  out  1  stop bit sampled low in last frame.

Behaviour:
- Reset (synchronous: applied at the clk edge where rst = 1): FSM to IDLE; counters cleared; dout = 0; rx_done = 0; rx_busy = 0; parity_err = 0; frame_err = 0; synchroniser flops set to 1.
- Reset mid-frame aborts the frame. No rx_done is issued and partial data is discarded.
- rx passes through a 2-flop synchroniser (reset value 1). Call its output rx_s. All decisions use rx_s.
- tick_count is $clog2(OVERSAMPLING_RATE) bits. It advances only on tick, wraps at OVERSAMPLING_RATE-1, and is cleared on every state entry. bit_index is $clog2(DATA_WD) bits.
- IDLE:
  - Requires armed = 1 and rx_s = 0 to enter START; rx_busy is set on that edge.
  - armed is set whenever rx_s = 1 in IDLE.
  - armed is cleared on leaving IDLE. This prevents a break condition (line held low) from retriggering.
- START:
  - On the tick where tick_count = OVERSAMPLING_RATE/2-1, sample rx_s (bit centre).
  - If rx_s = 1 (false start): go to IDLE, rx_busy <= 0, no flags change.
  - If rx_s = 0: go to DATA with tick_count cleared.
- DATA:
  - On each tick where tick_count = OVERSAMPLING_RATE-1, shift rx_s into shift_reg[bit_index] and increment bit_index.
  - After bit DATA_WD-1, go to PARITY if PARITY is nonzero, else STOP.
- PARITY: sample at the next full-bit point. par_bad = sampled bit differs from the expected value (XOR for 1, XNOR for 2).
- STOP:
  - Sample at the next full-bit point; frame_bad = (rx_s = 0).
  - Go to DONE without waiting for the end of the stop bit. This leaves half a bit of margin for back-to-back frames.
- DONE (exactly one clk):
  - dout <= shift_reg, rx_done <= 1, parity_err <= par_bad, frame_err <= frame_bad, rx_busy <= 0.
  - Next state is IDLE.
  - rx_done is 0 in every other state.
- Latency: rx_done rises 2 clk after the clk edge of the stop-sample tick (1 clk STOP->DONE, 1 clk register).
- Error flags hold their value until the next rx_done; no separate clear is needed.
- dout is stable between rx_done pulses, including across false starts.
- A tick coinciding with a state transition is consumed by the old state; the new state starts counting from 0.
- The state register is one-hot: IDLE, START, DATA, PARITY, STOP, DONE. Illegal encodings go to IDLE.

Decomposition:
- Package uart_pkg holds:
  - state one-hot localparams (shared with uart_tx),
  - parity codes PARITY_NONE = 0, PARITY_XOR = 1, PARITY_XNOR = 2,
  - the constant function for expected parity.
- Sub-module uart_sync2: 2-flop synchroniser with parameterised reset value, reusable for other async inputs.

Test Plan:
- Bench setup: tick every 4 clk. PARITY = 0. Frame is start, 0xA5 LSB first, stop.
  Required: rx_done pulses exactly once; dout = 0xA5; parity_err = 0; frame_err = 0; rx_busy high from start detection through DONE.
- PARITY = 1, frame 0x3C with parity bit 0 (XOR of 0x3C is 0) -> parity_err = 0. Repeat with parity bit 1 -> parity_err = 1, dout = 0x3C.
- Stop bit driven 0 on frame 0x55 -> frame_err = 1, dout = 0x55.
  Then hold rx low for 3 bit times: no new rx_done, rx_busy stays 0.
  Then release rx high and send 0x12 -> dout = 0x12, frame_err = 0.
- Glitch: rx low for 3 ticks, then high -> START aborts, rx_busy returns to 0, no rx_done, dout is unchanged from the previous value.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_done pulses, dout = 0x00 then 0xFF.
- rst asserted for 1 clk during DATA bit 3 of 0x81 -> all outputs 0 on the next clk, no rx_done.
  The following frame 0x7E is received correctly.
